// File: rtl/sm_run_ctrl_pkg.sv
// sm_run_ctrl_pkg: state/command encodings and hold-counter sizing for sm_run_ctrl
package sm_run_ctrl_pkg;
  typedef enum logic [1:0] {ST_RESET_HOLD = 2'b00, ST_HALT = 2'b01, ST_RUN = 2'b10, ST_STEP = 2'b11} state_t;
  typedef enum logic [1:0] {OP_RUN = 2'b00, OP_HALT = 2'b01, OP_STEP = 2'b10, OP_SET_LIMIT = 2'b11} cmd_op_t;
  localparam int HOLD_CNT_W = 8;
endpackage

// File: rtl/sm_run_step_counter.sv
// sm_run_step_counter: loadable down-counter flagging its last count, shared by STEP and RESET_HOLD
module sm_run_step_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  input  logic         i_dec,
  output logic         o_last
);
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk)
    r_cnt <= i_load ? i_val : (i_dec && r_cnt != '0) ? r_cnt - 1'b1 : r_cnt;
  assign o_last = r_cnt == W'(1);
endmodule

// File: rtl/sm_run_ctrl.sv
// sm_run_ctrl: run/halt/step controller with cycle budget for sm_top; SM_RUN_CTRL_BREAKPOINT_EN adds a PC breakpoint
module sm_run_ctrl
  import sm_run_ctrl_pkg::*;
#(
  parameter int CYCLE_W     = 32,
  parameter int HOLD_CYCLES = 4,
  parameter int DIV_W       = 4
) (
  input  logic               clkIn,
  input  logic               rst_p,
  input  logic               cmdValid,
  output logic               cmdReady,
  input  logic [1:0]         cmdOp,
  input  logic [CYCLE_W-1:0] cmdArg,
  input  logic [DIV_W-1:0]   clkDevideIn,
  output logic               clkEnable,
  output logic [DIV_W-1:0]   clkDevide,
  output logic               coreRst,
  output logic [CYCLE_W-1:0] cycleCount,
  output logic [1:0]         state,
`ifdef SM_RUN_CTRL_BREAKPOINT_EN
  input  logic [31:0]        pcIn,
  input  logic               bpEnable,
  input  logic [31:0]        bpAddr,
  output logic               bpHit,
`endif
  output logic               timeout
);
  localparam logic [HOLD_CNT_W-1:0] HOLD_N = HOLD_CNT_W'(HOLD_CYCLES);
  state_t               r_state;
  logic                 r_ready, r_en, r_rst, r_timeout;
  logic [CYCLE_W-1:0]   r_cnt, r_limit;
  logic [DIV_W-1:0]     r_div;
  cmd_op_t              w_op;
  logic                 w_acc, w_lim, w_bp, w_halt, w_go, w_ld, w_dec, w_last;
  logic [CYCLE_W-1:0]   w_cnt_nxt, w_ld_val;
  always_comb begin
    w_op      = cmd_op_t'(cmdOp);
    w_acc     = cmdValid && r_ready;
    w_cnt_nxt = (r_en && !(&r_cnt)) ? r_cnt + 1'b1 : r_cnt;
    w_lim     = r_en && r_limit != '0 && w_cnt_nxt >= r_limit;
    w_halt    = w_lim || w_bp || (r_state == ST_STEP && w_last);
    w_go      = w_acc && !w_halt && !r_timeout && r_state == ST_HALT && (w_op == OP_RUN || w_op == OP_STEP);
    w_ld      = rst_p || (w_go && w_op == OP_STEP);
    w_ld_val  = rst_p ? CYCLE_W'(HOLD_N) : (cmdArg == '0) ? CYCLE_W'(1) : cmdArg;
    w_dec     = r_state == ST_RESET_HOLD || r_state == ST_STEP;
  end
  sm_run_step_counter #(.W(CYCLE_W)) u_cnt (
    .clk    (clkIn),
    .i_load (w_ld),
    .i_val  (w_ld_val),
    .i_dec  (w_dec),
    .o_last (w_last)
  );
  always_ff @(posedge clkIn) begin
    if (rst_p) begin
      r_state   <= ST_RESET_HOLD;
      r_rst     <= 1'b1;
      r_en      <= 1'b0;
      r_ready   <= 1'b0;
      r_cnt     <= '0;
      r_limit   <= '0;
      r_timeout <= 1'b0;
      r_div     <= '0;
    end else if (r_state == ST_RESET_HOLD) begin
      if (w_last) begin
        r_state <= ST_HALT;
        r_rst   <= 1'b0;
        r_ready <= 1'b1;
      end
    end else begin
      r_cnt <= w_cnt_nxt;
      if (r_state == ST_HALT) r_div <= clkDevideIn;
      if (w_lim) r_timeout <= 1'b1;
      // a SET_LIMIT landing on the limit-hit edge still clears the flag it would set
      if (w_acc && w_op == OP_SET_LIMIT) begin
        r_limit   <= cmdArg;
        r_timeout <= 1'b0;
      end
      if (w_halt || (w_acc && w_op == OP_HALT)) begin
        r_state <= ST_HALT;
        r_en    <= 1'b0;
        r_ready <= 1'b1;
      end else if (w_go) begin
        r_state <= w_op == OP_STEP ? ST_STEP : ST_RUN;
        r_en    <= 1'b1;
        r_ready <= w_op != OP_STEP;
      end
    end
  end
`ifdef SM_RUN_CTRL_BREAKPOINT_EN
  logic r_bp;
  assign w_bp = bpEnable && pcIn == bpAddr && r_en;
  always_ff @(posedge clkIn)
    r_bp <= rst_p ? 1'b0 : w_bp ? 1'b1 : w_go ? 1'b0 : r_bp;
  assign bpHit = r_bp;
`else
  assign w_bp = 1'b0;
`endif
  assign cmdReady   = r_ready;
  assign clkEnable  = r_en;
  assign clkDevide  = r_div;
  assign coreRst    = r_rst;
  assign cycleCount = r_cnt;
  assign state      = r_state;
  assign timeout    = r_timeout;
endmodule

// File: tb/tb_sm_run_ctrl.sv
// tb_sm_run_ctrl: directed scoreboard bench for sm_run_ctrl (breakpoint steps when SM_RUN_CTRL_BREAKPOINT_EN)
module tb_sm_run_ctrl;
  logic        clkIn = 1'b0, rst_p = 1'b1, cmdValid = 1'b0;
  logic [1:0]  cmdOp = 2'b00;
  logic [31:0] cmdArg = '0;
  logic [3:0]  clkDevideIn = '0;
  logic        cmdReady, clkEnable, coreRst, timeout;
  logic [3:0]  clkDevide;
  logic [31:0] cycleCount;
  logic [1:0]  state;
`ifdef SM_RUN_CTRL_BREAKPOINT_EN
  logic [31:0] pcIn = '0, bpAddr = '0;
  logic        bpEnable = 1'b0;
  logic        bpHit;
`endif
  sm_run_ctrl dut (
    .clkIn       (clkIn),
    .rst_p       (rst_p),
    .cmdValid    (cmdValid),
    .cmdReady    (cmdReady),
    .cmdOp       (cmdOp),
    .cmdArg      (cmdArg),
    .clkDevideIn (clkDevideIn),
    .clkEnable   (clkEnable),
    .clkDevide   (clkDevide),
    .coreRst     (coreRst),
    .cycleCount  (cycleCount),
    .state       (state),
`ifdef SM_RUN_CTRL_BREAKPOINT_EN
    .pcIn        (pcIn),
    .bpEnable    (bpEnable),
    .bpAddr      (bpAddr),
    .bpHit       (bpHit),
`endif
    .timeout     (timeout)
  );
  always #5 clkIn = ~clkIn;
  int en_cnt = 0;
  always @(posedge clkIn) if (clkEnable === 1'b1) en_cnt <= en_cnt + 1;
  typedef struct {string tag; logic [31:0] v;} exp_t;
  exp_t sb[$];
  int passed = 0, total = 0;
  task automatic tick();
    @(posedge clkIn);
    #1;
  endtask
  task automatic send(input logic [1:0] op, input logic [31:0] arg);
    cmdValid = 1'b1;
    cmdOp = op;
    cmdArg = arg;
    tick();
    cmdValid = 1'b0;
  endtask
  task automatic e(input string tag, input logic [31:0] v);
    sb.push_back('{tag, v});
  endtask
  task automatic c(input logic [31:0] obs);
    exp_t x;
    total++;
    if (sb.size() == 0) begin
      $error("FAIL sb_empty observed=%0h expected=none", obs);
      return;
    end
    x = sb.pop_front();
    assert (obs === x.v) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", x.tag, obs, x.v);
  endtask
  task automatic wait_halt(input int bound, output bit rdy_seen);
    int n = 0;
    rdy_seen = 1'b0;
    while (state !== 2'b01 && n < bound) begin
      if (cmdReady === 1'b1) rdy_seen = 1'b1;
      tick();
      n++;
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1);
  end
  initial begin
    int n, e0;
    bit seen;
    e("rst_state", 0); e("rst_core", 1); e("rst_en", 0); e("rst_rdy", 0);
    e("rst_cnt", 0); e("rst_to", 0); e("rst_div", 0);
    repeat (3) tick();
    c(32'(state)); c(32'(coreRst)); c(32'(clkEnable)); c(32'(cmdReady));
    c(cycleCount); c(32'(timeout)); c(32'(clkDevide));
    rst_p = 1'b0;
    n = 0;
    e("hold_cycles", 4);
    while (coreRst === 1'b1 && n < 20) begin n++; tick(); end
    c(32'(n));
    e("idle_state", 1); e("idle_rdy", 1); e("idle_en", 0); e("idle_cnt", 0);
    c(32'(state)); c(32'(cmdReady)); c(32'(clkEnable)); c(cycleCount);
    e0 = en_cnt;
    e("run_en", 1);
    send(2'b00, 0);
    c(32'(clkEnable));
    repeat (9) tick();
    send(2'b01, 0);
    e("run_edges", 10); e("run_cnt", 10); e("run_halt", 1); e("run_en_off", 0);
    c(32'(en_cnt - e0)); c(cycleCount); c(32'(state)); c(32'(clkEnable));
    e0 = en_cnt;
    e("step_state", 3); e("step_rdy", 0);
    send(2'b10, 5);
    c(32'(state)); c(32'(cmdReady));
    wait_halt(50, seen);
    e("step5_edges", 5); e("step_rdy_seen", 0); e("step5_cnt", 15);
    c(32'(en_cnt - e0)); c(32'(seen)); c(cycleCount);
    e0 = en_cnt;
    send(2'b10, 0);
    wait_halt(50, seen);
    e("step0_edges", 1); e("step0_cnt", 16);
    c(32'(en_cnt - e0)); c(cycleCount);
    e("lim_to_clr", 0);
    send(2'b11, 300);
    c(32'(timeout));
    send(2'b00, 0);
    wait_halt(400, seen);
    e("lim_cnt", 300); e("lim_to", 1); e("lim_en", 0);
    c(cycleCount); c(32'(timeout)); c(32'(clkEnable));
    send(2'b00, 0);
    e("to_run_state", 1); e("to_run_en", 0); e("to_run_cnt", 300);
    c(32'(state)); c(32'(clkEnable)); c(cycleCount);
    send(2'b11, 0);
    e("lim0_to", 0);
    c(32'(timeout));
    send(2'b00, 0);
    e("resume_state", 2); e("resume_en", 1);
    c(32'(state)); c(32'(clkEnable));
    clkDevideIn = 4'b0110;
    repeat (3) tick();
    e("div_run", 0);
    c(32'(clkDevide));
    send(2'b01, 0);
    e("div_halt_edge", 0); e("div_halt_state", 1);
    c(32'(clkDevide)); c(32'(state));
    tick();
    e("div_after", 6);
    c(32'(clkDevide));
    send(2'b00, 0);
    send(2'b10, 2);
    e("step_in_run_state", 2); e("step_in_run_rdy", 1); e("step_in_run_en", 1);
    c(32'(state)); c(32'(cmdReady)); c(32'(clkEnable));
    send(2'b01, 0);
    send(2'b10, 20);
    repeat (3) tick();
    e("midstep_state", 3);
    c(32'(state));
    rst_p = 1'b1;
    tick();
    e("mrst_state", 0); e("mrst_core", 1); e("mrst_en", 0); e("mrst_rdy", 0);
    e("mrst_cnt", 0); e("mrst_div", 0);
    c(32'(state)); c(32'(coreRst)); c(32'(clkEnable)); c(32'(cmdReady));
    c(cycleCount); c(32'(clkDevide));
    rst_p = 1'b0;
    wait_halt(20, seen);
    e("mrst_halt", 1);
    c(32'(state));
    e0 = en_cnt;
    send(2'b11, 3);
    send(2'b10, 10);
    wait_halt(50, seen);
    e("lstep_edges", 3); e("lstep_cnt", 3); e("lstep_to", 1);
    c(32'(en_cnt - e0)); c(cycleCount); c(32'(timeout));
`ifdef SM_RUN_CTRL_BREAKPOINT_EN
    send(2'b11, 0);
    bpAddr = 32'h40;
    bpEnable = 1'b1;
    pcIn = 32'h0;
    send(2'b00, 0);
    repeat (2) tick();
    pcIn = 32'h40;
    tick();
    e("bp_state", 1); e("bp_en", 0); e("bp_hit", 1);
    c(32'(state)); c(32'(clkEnable)); c(32'(bpHit));
    pcIn = 32'h0;
    send(2'b00, 0);
    e("bp_clr", 0); e("bp_run", 2);
    c(32'(bpHit)); c(32'(state));
    send(2'b01, 0);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
